// File: rtl/unsigned_seq_divider_w8.sv
// unsigned_seq_divider_w8: sequential restoring divider, q = z / y, r = z % y.
// Recovers one W-bit multiplier operand (and the residual) from a 2W-bit product.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake for z (2W bits) and y (W bits)
//   out_valid / out_ready output handshake for q, r (W bits each), ovf, dz
//   ovf                   quotient needs more than W bits (z[2W-1:W] >= y)
//   dz                    divide by zero (y == 0): q = all-ones, r = z[W-1:0]
//
// Build option: define UDIV_SAT_EN to report an overflow as q = r = all-ones;
// otherwise an overflow reports q = r = 0 and the consumer relies on ovf.
module unsigned_seq_divider_w8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] z,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           ovf,
    output logic           dz
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   y_q;
    logic [W-1:0]   zlo_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   q_q;
    logic [W-1:0]   r_q;
    logic           ovf_q;
    logic           dz_q;
    logic           out_valid_q;

    logic [W:0]     sh;
    logic [W+1:0]   diff;
    logic           neg;
    logic [W-1:0]   rem_d;
    logic [W-1:0]   quo_d;
    logic           unused_ok;

`ifdef UDIV_SAT_EN
    localparam logic [W-1:0] OVF_VAL = '1;
`else
    localparam logic [W-1:0] OVF_VAL = '0;
`endif

    // One restoring step. The partial remainder is always < y, so the
    // shifted value fits W+1 bits; one extra bit carries the borrow.
    always_comb begin
        sh        = {rem_q, zlo_q[W-1]};
        diff      = {1'b0, sh} - {2'b00, y_q};
        neg       = diff[W+1];
        rem_d     = neg ? sh[W-1:0] : diff[W-1:0];
        quo_d     = {quo_q[W-2:0], ~neg};
        // diff[W] is zero whenever the difference is kept.
        unused_ok = diff[W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            y_q         <= '0;
            zlo_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        y_q   <= y;
                        zlo_q <= z[W-1:0];
                        if (y == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            dz_q        <= 1'b1;
                            ovf_q       <= 1'b0;
                            q_q         <= '1;
                            r_q         <= z[W-1:0];
                        end else if (z[2*W-1:W] >= y) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            dz_q        <= 1'b0;
                            ovf_q       <= 1'b1;
                            q_q         <= OVF_VAL;
                            r_q         <= OVF_VAL;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CW'(W - 1);
                            rem_q   <= z[2*W-1:W];
                            quo_q   <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    zlo_q <= {zlo_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        q_q         <= quo_d;
                        r_q         <= rem_d;
                        ovf_q       <= 1'b0;
                        dz_q        <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready is a decode of the state, masked so it stays low during reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign r         = r_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_unsigned_seq_divider_w8.sv
// tb_unsigned_seq_divider_w8: directed and random
// checks of the sequential divider vs a scoreboard.
module tb_unsigned_seq_divider_w8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;
  logic        dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] z;
    logic [7:0]  y;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

`ifdef UDIV_SAT_EN
  localparam logic [7:0] OVF_EXP = 8'hFF;
`else
  localparam logic [7:0] OVF_EXP = 8'h00;
`endif

  always #5 clk = ~clk;

  unsigned_seq_divider_w8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .ovf       (ovf),
    .dz        (dz)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: obs %0d exp %0d",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [15:0] zz,
    input logic [7:0]  yy
  );
    exp_t e;
    e.z   = zz;
    e.y   = yy;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    if (yy == 8'd0) begin
      e.dz = 1'b1;
      e.q  = 8'hFF;
      e.r  = zz[7:0];
    end else if (zz[15:8] >= yy) begin
      e.ovf = 1'b1;
      e.q   = OVF_EXP;
      e.r   = OVF_EXP;
    end else begin
      e.q = 8'(zz / 16'(yy));
      e.r = 8'(zz % 16'(yy));
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_q", q, mon_e.q);
        chk("sb_r", r, mon_e.r);
        chk("sb_ovf", ovf, mon_e.ovf);
        chk("sb_dz", dz, mon_e.dz);
        if (!mon_e.dz && !mon_e.ovf) begin
          chk("identity",
              16'(16'(q) * 16'(mon_e.y)
                  + 16'(r)),
              mon_e.z);
          chk("r_lt_y", r < mon_e.y, 1);
        end
      end
    end
  end

  task automatic send(
    input logic [15:0] zz,
    input logic [7:0]  yy
  );
    bit ok;
    ok = 1'b0;
    sb.push_back(model(zz, yy));
    z        = zz;
    y        = yy;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic wait_valid(
    input int    exp_lat,
    input string tag
  );
    int lat;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_to"}, out_valid, 1);
    chk(tag, lat, exp_lat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    bit          hs;
    logic [7:0]  ry;
    logic [15:0] rz;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = '0;
    y         = '0;

    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(16'd20000, 8'd100);
    wait_valid(9, "lat_t1");
    chk("t1_q", q, 200);
    chk("t1_r", r, 0);
    handshake();

    send(16'd1000, 8'd7);
    wait_valid(9, "lat_t2");
    chk("t2_q", q, 142);
    chk("t2_r", r, 6);
    handshake();

    send(16'd65280, 8'd255);
    wait_valid(1, "lat_ovf");
    chk("ovf_flag", ovf, 1);
    chk("ovf_q", q, OVF_EXP);
    chk("ovf_r", r, OVF_EXP);
    handshake();

    send(16'd1234, 8'd0);
    wait_valid(1, "lat_dz");
    chk("dz_flag", dz, 1);
    chk("dz_ovf", ovf, 0);
    chk("dz_q", q, 255);
    chk("dz_r", r, 8'hD2);
    handshake();

    out_ready = 1'b0;
    send(16'd40000, 8'd200);
    wait_valid(9, "lat_bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        z        = 16'd100;
        y        = 8'd3;
        in_valid = 1'b1;
      end
      if (i == 2) in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_q", q, 200);
      chk("bp_r", r, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    handshake();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_extra", out_valid, 0);

    send(16'd50000, 8'd250);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_in_ready", in_ready, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'd50000, 8'd250);
    wait_valid(9, "lat_after_abort");
    chk("abort_redo_q", q, 200);
    chk("abort_redo_r", r, 0);
    handshake();

    for (int n = 0; n < 2000; n++) begin
      ry = 8'($urandom_range(1, 255));
      rz = 16'($urandom_range(
             0, int'(ry) * 256 - 1));
      send(rz, ry);
      hs = 1'b0;
      for (int c = 0; c < 100; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        hs = out_valid && out_ready;
        @(posedge clk);
        #1;
        if (hs) break;
      end
      chk("rand_hs", hs, 1);
    end

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
